// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the word-mixing logic.
// Holds the word type, the rotate/shift amounts of the sigma functions,
// the packed result bundle and pure rotate/shift helpers. The helpers
// are also meant for the message-schedule sigma1 (17, 19, SHR10).
package sha256_pkg;

  typedef logic [31:0] word_t;

  // Sigma0: ROTR2 ^ ROTR13 ^ ROTR22
  localparam int S0_R0 = 2;
  localparam int S0_R1 = 13;
  localparam int S0_R2 = 22;

  // Sigma1: ROTR6 ^ ROTR11 ^ ROTR25
  localparam int S1_R0 = 6;
  localparam int S1_R1 = 11;
  localparam int S1_R2 = 25;

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  localparam int s0_R0 = 7;
  localparam int s0_R1 = 18;
  localparam int s0_SH = 3;

  // One result word per function, always derived from a single operand.
  typedef struct packed {
    word_t big_sigma0;
    word_t big_sigma1;
    word_t small_sigma0;
  } sigma_res_t;

  // 32-bit rotate right. n=0 gives w unchanged (w << 32 is zero).
  function automatic word_t rotr(input word_t w, input int n);
    return (w >> n) | (w << (32 - n));
  endfunction

  // Logical shift right, zero-filling the top bits.
  function automatic word_t shr(input word_t w, input int n);
    return w >> n;
  endfunction

endpackage

// File: rtl/sha256_sigma_unit_if.sv
// Operand/result bundle of the sigma unit.
//   in_valid     : qualifies x
//   x            : operand word
//   big_sigma0   : Sigma0(x)
//   big_sigma1   : Sigma1(x)
//   small_sigma0 : sigma0(x)
//   out_valid    : the three results belong to a qualified x
// master drives the operand, slave (the unit) drives the results.
interface sha256_sigma_unit_if;
  import sha256_pkg::*;

  logic  in_valid;
  word_t x;
  word_t big_sigma0;
  word_t big_sigma1;
  word_t small_sigma0;
  logic  out_valid;

  modport master (
    output in_valid, x,
    input  big_sigma0, big_sigma1, small_sigma0, out_valid
  );

  modport slave (
    input  in_valid, x,
    output big_sigma0, big_sigma1, small_sigma0, out_valid
  );

endinterface

// File: rtl/sha256_sigma_comb.sv
// Purely combinational Sigma0 / Sigma1 / sigma0 of one 32-bit word.
//   x_i   : operand word
//   res_o : all three function results for x_i
// Rotations are plain rewiring; only the 3-input XORs cost logic.
module sha256_sigma_comb
  import sha256_pkg::*;
(
  input  word_t      x_i,
  output sigma_res_t res_o
);

  always_comb begin
    res_o              = '0;
    res_o.big_sigma0   = rotr(x_i, S0_R0) ^ rotr(x_i, S0_R1) ^ rotr(x_i, S0_R2);
    res_o.big_sigma1   = rotr(x_i, S1_R0) ^ rotr(x_i, S1_R1) ^ rotr(x_i, S1_R2);
    res_o.small_sigma0 = rotr(x_i, s0_R0) ^ rotr(x_i, s0_R1) ^ shr(x_i, s0_SH);
  end

endmodule

// File: rtl/sha256_sigma_unit.sv
// SHA-256 word-mixing unit: Sigma0, Sigma1 and sigma0 of one word in parallel.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (tie high when unused)
//   bus : slave side of sha256_sigma_unit_if (in_valid/x in, results out)
// OUT_REG=1: results and out_valid registered, 1-cycle latency, one word
//            per clock; results hold while in_valid is low.
// OUT_REG=0: results are f(x) combinationally, out_valid = in_valid, and
//            reset has no effect.
module sha256_sigma_unit
  import sha256_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  sha256_sigma_unit_if.slave   bus
);

  sigma_res_t res_c;

  sha256_sigma_comb u_comb (
    .x_i   (bus.x),
    .res_o (res_c)
  );

  if (OUT_REG) begin : g_reg
    sigma_res_t res_d, res_q;
    logic       vld_d, vld_q;

    // Results load as one 96-bit unit so the three words never come
    // from different operands.
    always_comb begin
      res_d = res_q;
      vld_d = bus.in_valid;
      if (bus.in_valid) res_d = res_c;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        res_q <= '0;
        vld_q <= 1'b0;
      end else begin
        res_q <= res_d;
        vld_q <= vld_d;
      end
    end

    assign bus.big_sigma0   = res_q.big_sigma0;
    assign bus.big_sigma1   = res_q.big_sigma1;
    assign bus.small_sigma0 = res_q.small_sigma0;
    assign bus.out_valid    = vld_q;
  end else begin : g_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst   = ^{clk, rst};

    assign bus.big_sigma0   = res_c.big_sigma0;
    assign bus.big_sigma1   = res_c.big_sigma1;
    assign bus.small_sigma0 = res_c.small_sigma0;
    assign bus.out_valid    = bus.in_valid;
  end

endmodule

// File: tb/tb_sha256_sigma_unit.sv
// Testbench for sha256_sigma_unit: a registered (OUT_REG=1) and a
// combinational (OUT_REG=0) instance share one stimulus stream.
module tb_sha256_sigma_unit;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_sigma_unit_if bus_r ();
  sha256_sigma_unit_if bus_c ();

  sha256_sigma_unit #(.OUT_REG(1'b1)) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (bus_r.slave)
  );

  sha256_sigma_unit #(.OUT_REG(1'b0)) u_comb (
    .clk (clk),
    .rst (rst),
    .bus (bus_c.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    word_t      x;
    sigma_res_t exp;
  } vec_t;

  vec_t tbl [5];

  // Bit-level reference: output bit i of ROTRn is input bit (i+n) mod 32.
  function automatic sigma_res_t ref_f(input word_t w);
    sigma_res_t r;
    for (int i = 0; i < 32; i++) begin
      r.big_sigma0[i]   = w[(i + 2) % 32] ^ w[(i + 13) % 32] ^ w[(i + 22) % 32];
      r.big_sigma1[i]   = w[(i + 6) % 32] ^ w[(i + 11) % 32] ^ w[(i + 25) % 32];
      r.small_sigma0[i] = w[(i + 7) % 32] ^ w[(i + 18) % 32] ^ ((i < 29) ? w[(i + 3) % 32] : 1'b0);
    end
    return r;
  endfunction

  task automatic drive(input logic v, input word_t w);
    bus_r.in_valid = v;
    bus_r.x        = w;
    bus_c.in_valid = v;
    bus_c.x        = w;
  endtask

  task automatic chk_r(input string nm, input sigma_res_t e, input logic ev);
    sigma_res_t a;
    a = '{bus_r.big_sigma0, bus_r.big_sigma1, bus_r.small_sigma0};
    n_tests++;
    if (a !== e || bus_r.out_valid !== ev) begin
      n_fail++;
      $display("FAIL reg:%s got %h/%h/%h v=%b expected %h/%h/%h v=%b", nm,
               a.big_sigma0, a.big_sigma1, a.small_sigma0, bus_r.out_valid,
               e.big_sigma0, e.big_sigma1, e.small_sigma0, ev);
    end
  endtask

  task automatic chk_c(input string nm, input sigma_res_t e, input logic ev);
    sigma_res_t a;
    a = '{bus_c.big_sigma0, bus_c.big_sigma1, bus_c.small_sigma0};
    n_tests++;
    if (a !== e || bus_c.out_valid !== ev) begin
      n_fail++;
      $display("FAIL comb:%s got %h/%h/%h v=%b expected %h/%h/%h v=%b", nm,
               a.big_sigma0, a.big_sigma1, a.small_sigma0, bus_c.out_valid,
               e.big_sigma0, e.big_sigma1, e.small_sigma0, ev);
    end
  endtask

  initial begin
    sigma_res_t ones_exp, exp_q, e;
    logic       exp_v, v;
    word_t      w;

    tbl[0] = '{32'h0000_3FFF, '{32'h3F07F3FE, 32'h03FFFF78, 32'hF1FFC780}};
    tbl[1] = '{32'h0000_0001, '{32'h40080400, 32'h04200080, 32'h02004000}};
    tbl[2] = '{32'h0000_0000, '{32'h00000000, 32'h00000000, 32'h00000000}};
    tbl[3] = '{32'hFFFF_FFFF, '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF}};
    tbl[4] = '{32'h8000_0000, '{32'h20040200, 32'h02100040, 32'h11002000}};
    ones_exp = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF};

    // Reset held with a valid all-ones operand present.
    rst = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    chk_r("reset_state", '0, 1'b0);
    chk_c("comb_ignores_reset", ones_exp, 1'b1);

    // First load happens on the edge that releases reset.
    rst = 1'b1;
    @(negedge clk);
    chk_r("first_load_after_reset", ones_exp, 1'b1);

    // Table vectors, one per cycle (back-to-back stream).
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tbl[i].x);
      #1 chk_c($sformatf("vec%0d", i), tbl[i].exp, 1'b1);
      @(negedge clk);
      chk_r($sformatf("vec%0d", i), tbl[i].exp, 1'b1);
    end

    // in_valid low: registered results hold, valid drops.
    drive(1'b0, 32'h1234_5678);
    #1 chk_c("idle_comb", ref_f(32'h1234_5678), 1'b0);
    @(negedge clk);
    chk_r("hold_when_idle", tbl[4].exp, 1'b0);

    // Stream interrupted by an asynchronous reset between edges.
    drive(1'b1, tbl[0].x);
    @(negedge clk);
    chk_r("stream_a", tbl[0].exp, 1'b1);
    drive(1'b1, tbl[1].x);
    @(posedge clk);
    #2 chk_r("stream_b", tbl[1].exp, 1'b1);
    #1 rst = 1'b0;
    #1 chk_r("async_clear", '0, 1'b0);
    chk_c("async_comb_unaffected", tbl[1].exp, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk_r("word_dropped_in_reset", '0, 1'b0);
    drive(1'b0, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    chk_r("idle_after_release", '0, 1'b0);

    // Random operands, random valid gaps, against the bit-level model.
    exp_q = '0;
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      w = $urandom;
      drive(v, w);
      e = ref_f(w);
      #1 chk_c("rand", e, v);
      if (v) exp_q = e;
      exp_v = v;
      @(negedge clk);
      chk_r("rand", exp_q, exp_v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_sigma_unit.md
Name: sha256_sigma_unit

Overview:
- Registered SHA-256 word-mixing unit. Takes one 32-bit word and computes three functions in parallel:
  - Sigma0 (Function1)
  - Sigma1 (Function2)
  - sigma0 (Function3)
- Sits beside the compression round / message-schedule logic of the Bitcoin hasher. Feeds the temporary-word adders and the W[t] expansion.
- One clock domain. Outputs are registered.

Parameters:
- OUT_REG, 1: 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational from x, and out_valid follows in_valid.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset. Tied high when unused.
- in_valid  input  1  qualifies x; the registers load only when this is high.
- x  input  32  operand word.
- big_sigma0  output  32  ROTR2(x) ^ ROTR13(x) ^ ROTR22(x).
- big_sigma1  output  32  ROTR6(x) ^ ROTR11(x) ^ ROTR25(x).
- small_sigma0  output  32  ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- out_valid  output  1  high when the three outputs hold a result for a qualified x.

Behaviour:
- Arithmetic:
  - ROTRn(x) = (x >> n) | (x << (32-n)), 32-bit.
  - SHR3 is a logical shift; zero-fill the top 3 bits.
  - XOR is bitwise. There is no carry, and no width growth.
- Reset (rst=0, asynchronous): big_sigma0, big_sigma1 and small_sigma0 go to 32'h0 and out_valid goes to 0 immediately, with no clock edge needed.
- Reset release is synchronous to the next rising clk edge. The first load can occur on that edge.
- OUT_REG=1, on each rising edge with rst=1:
  - in_valid=1: all three outputs load f(x) and out_valid goes to 1. Latency is exactly 1 cycle.
  - in_valid=0: the outputs hold their previous value and out_valid goes to 0.
- Back-to-back valid inputs give one result per cycle; throughput is 1 word/clk.
- Reset asserted mid-stream clears the outputs and out_valid. A valid word presented on the edge coinciding with reset is dropped.
- OUT_REG=0: outputs are f(x) combinationally; out_valid = in_valid. Reset has no effect on outputs in this mode.
- The three outputs always derive from the same sampled x. Never mix words across outputs.
- No state machine. State is the 96-bit result register plus the valid flop.

Decomposition:
- Shared package sha256_pkg holds:
  - word_t (32-bit);
  - rotation constants S0_R = 2, 13, 22; S1_R = 6, 11, 25; s0_R = 7, 18 with s0_SH = 3;
  - pure functions rotr(word_t, int) and shr(word_t, int), reusable by Function4 (sigma1: 17, 19, SHR10) later.
- One sub-module is natural: sha256_sigma_comb. It is purely combinational, computing all three values. The top wraps it with the output register and valid flop.

Test Plan:
- Reset: hold rst=0 with x=32'hFFFFFFFF, in_valid=1 -> all outputs 32'h0 and out_valid=0. Release, and after 1 edge: big_sigma0=32'hFFFFFFFF, big_sigma1=32'hFFFFFFFF, small_sigma0=32'h1FFFFFFF.
- x=32'h00003FFF, in_valid=1 -> next cycle big_sigma0=32'h3F07F3FE, big_sigma1=32'h03FFFF78, small_sigma0=32'hF1FFC780, out_valid=1.
- x=32'h00000001 -> big_sigma0=32'h40080400, big_sigma1=32'h04200080, small_sigma0=32'h02004000.
- x=32'h0 -> all outputs 32'h0. Then in_valid=0 with x changed -> outputs hold and out_valid=0.
- Back-to-back stream 00003FFF, 00000001, FFFFFFFF on consecutive cycles -> the matching results appear on consecutive cycles. Assert rst=0 asynchronously between edges in the middle of the stream -> outputs clear at once.
- Random: 10k random x compared against the reference model. Run once with OUT_REG=1 (1-cycle delayed) and once with OUT_REG=0 (same-cycle).
